// File: rtl/score_scan_ctrl.sv
// Two-player score keeper with round-robin increment arbiter and 4-slot
// display scan that time-shares one binary-to-BCD converter.
//
// Parameters:
//   SCAN_DIV  - clock cycles per digit slot (2 .. 2^20)
//   MAX_SCORE - per-player saturation value (1 .. 15)
// Optional build macro:
//   SCORE_LZB_EN - blank a tens digit whose converted value is 0
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      synchronous active-low reset
//   req_inc_i   per-player increment request (level)
//   clr_i       synchronous clear of both scores
//   ack_o       one-cycle grant pulse per player
//   bin_out_o   score presented to the shared converter
//   bcd0_i      converter ones digit
//   bcd1_i      converter tens digit
//   an_o        active-low digit enables
//   digit_o     BCD value of the enabled digit
//   score0_o    player 0 score
//   score1_o    player 1 score
module score_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned MAX_SCORE = 15
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_inc_i,
  input  logic       clr_i,
  output logic [1:0] ack_o,
  output logic [3:0] bin_out_o,
  input  logic [3:0] bcd0_i,
  input  logic [3:0] bcd1_i,
  output logic [3:0] an_o,
  output logic [3:0] digit_o,
  output logic [3:0] score0_o,
  output logic [3:0] score1_o
);

  localparam int unsigned CW =
    (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(SCAN_DIV - 1);
  localparam logic [3:0] SAT = 4'(MAX_SCORE);

  typedef enum logic [1:0] {
    P0_ONES = 2'd0,
    P0_TENS = 2'd1,
    P1_ONES = 2'd2,
    P1_TENS = 2'd3
  } slot_e;

  logic [3:0]    score0_q, score0_d;
  logic [3:0]    score1_q, score1_d;
  logic [1:0]    ack_q, ack_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  slot_e         idx_q, idx_d;
  logic          load_q, load_d;
  logic [3:0]    bin_q, bin_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    digit_q, digit_d;

  logic [1:0]    elig;
  logic [1:0]    gnt;
  logic          tick;
  slot_e         idx_nxt;

  function automatic logic [3:0] sat_inc(
    input logic [3:0] s
  );
    return (s >= SAT) ? s : s + 4'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      score0_q <= '0;
      score1_q <= '0;
      ack_q    <= '0;
      rr_q     <= 1'b1;
      cnt_q    <= '0;
      idx_q    <= P1_TENS;
      load_q   <= 1'b0;
      bin_q    <= '0;
      an_q     <= 4'b1111;
      digit_q  <= '0;
    end else begin
      score0_q <= score0_d;
      score1_q <= score1_d;
      ack_q    <= ack_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      load_q   <= load_d;
      bin_q    <= bin_d;
      an_q     <= an_d;
      digit_q  <= digit_d;
    end
  end

  // A player holding ack this cycle is ineligible, so
  // a held request increments at most every 2 cycles.
  assign elig = req_inc_i & ~ack_q;

  always_comb begin
    gnt = 2'b00;
    if (!clr_i) begin
      unique case (1'b1)
        (elig == 2'b11): gnt = rr_q ? 2'b01 : 2'b10;
        (elig == 2'b01): gnt = 2'b01;
        (elig == 2'b10): gnt = 2'b10;
        default:         gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    score0_d = score0_q;
    score1_d = score1_q;
    rr_d     = rr_q;
    ack_d    = gnt;
    if (clr_i) begin
      score0_d = '0;
      score1_d = '0;
    end else begin
      if (gnt[0]) begin
        score0_d = sat_inc(score0_q);
        rr_d     = 1'b0;
      end
      if (gnt[1]) begin
        score1_d = sat_inc(score1_q);
        rr_d     = 1'b1;
      end
    end
  end

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    idx_nxt = P0_ONES;
    unique case (idx_q)
      P0_ONES: idx_nxt = P0_TENS;
      P0_TENS: idx_nxt = P1_ONES;
      P1_ONES: idx_nxt = P1_TENS;
      P1_TENS: idx_nxt = P0_ONES;
      default: idx_nxt = P0_ONES;
    endcase
  end

  // Tick loads the converter with the post-arbitration
  // score; the following cycle latches its result.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    load_d  = 1'b0;
    bin_d   = bin_q;
    an_d    = an_q;
    digit_d = digit_q;
    if (tick) begin
      cnt_d  = '0;
      idx_d  = idx_nxt;
      load_d = 1'b1;
      bin_d  = idx_nxt[1] ? score1_d : score0_d;
    end
    if (load_q) begin
      digit_d = idx_q[0] ? bcd1_i : bcd0_i;
      unique case (idx_q)
        P0_ONES: an_d = 4'b1110;
        P0_TENS: an_d = 4'b1101;
        P1_ONES: an_d = 4'b1011;
        P1_TENS: an_d = 4'b0111;
        default: an_d = 4'b1111;
      endcase
`ifdef SCORE_LZB_EN
      if (idx_q[0] && (bcd1_i == 4'd0)) begin
        an_d    = 4'b1111;
        digit_d = '0;
      end
`endif
    end
  end

  assign ack_o     = ack_q;
  assign bin_out_o = bin_q;
  assign an_o      = an_q;
  assign digit_o   = digit_q;
  assign score0_o  = score0_q;
  assign score1_o  = score1_q;

endmodule

// File: tb/tb_score_scan_ctrl.sv
// Directed bench for score_scan_ctrl with a behavioural
// BCD converter; SCAN_DIV=4, MAX_SCORE=15.
module tb_score_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic       clr;
  logic [1:0] ack;
  logic [3:0] bin;
  logic [3:0] bcd0;
  logic [3:0] bcd1;
  logic [3:0] an;
  logic [3:0] digit;
  logic [3:0] s0;
  logic [3:0] s1;

  int checks = 0;
  int failures = 0;

  score_scan_ctrl #(
    .SCAN_DIV (4),
    .MAX_SCORE(15)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_inc_i(req),
    .clr_i    (clr),
    .ack_o    (ack),
    .bin_out_o(bin),
    .bcd0_i   (bcd0),
    .bcd1_i   (bcd1),
    .an_o     (an),
    .digit_o  (digit),
    .score0_o (s0),
    .score1_o (s1)
  );

  assign bcd0 = 4'(bin % 4'd10);
  assign bcd1 = 4'(bin / 4'd10);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves rst_n released at a negedge; the next
  // posedge is the first active edge after reset.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    clr   = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  task automatic wait_an(
    input logic [3:0] tgt,
    input string tag
  );
    bit hit = 0;
    for (int i = 0; i < 24 && !hit; i++) begin
      step(1);
      if (an == tgt) hit = 1;
    end
    if (!hit) chk(tag, an, tgt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req   = 2'b00;
    clr   = 1'b0;

    // reset state
    step(3);
    chk("rst_an", an, 4'b1111);
    chk("rst_digit", digit, 4'd0);
    chk("rst_ack", ack, 2'b00);
    chk("rst_bin", bin, 4'd0);
    chk("rst_s0", s0, 4'd0);
    chk("rst_s1", s1, 4'd0);

    // idle scan: first tick at edge 4, first an at 5
    rst_n = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      logic [3:0] e;
      step(1);
      if (k < 5) e = 4'b1111;
      else e = ~(4'b0001 << (((k - 5) / 4) % 4));
      chk($sformatf("scan_an%0d", k), an, e);
      chk($sformatf("scan_dig%0d", k), digit, 4'd0);
    end

    // both players held: alternate grants
    do_reset();
    req = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk($sformatf("rr_ack%0d", k), ack,
          (k % 2) ? 2'b01 : 2'b10);
      chk($sformatf("rr_s0_%0d", k), s0, (k + 1) / 2);
      chk($sformatf("rr_s1_%0d", k), s1, k / 2);
    end
    req = 2'b00;

    // saturation at 15
    do_reset();
    req = 2'b01;
    step(30);
    chk("sat_s0_pre", s0, 4'd15);
    chk("sat_ack_pre", ack, 2'b00);
    step(1);
    chk("sat_ack", ack, 2'b01);
    chk("sat_s0", s0, 4'd15);
    req = 2'b00;
    step(17);
    wait_an(4'b1110, "sat_wait_p0o");
    chk("sat_p0_ones", digit, 4'd5);
    step(4);
    chk("sat_an_p0t", an, 4'b1101);
    chk("sat_p0_tens", digit, 4'd1);

    // clear beats a simultaneous request
    do_reset();
    req = 2'b10;
    step(23);
    chk("clr_s1_pre", s1, 4'd12);
    req = 2'b00;
    step(1);
    chk("clr_ack_idle", ack, 2'b00);
    req = 2'b10;
    clr = 1'b1;
    step(1);
    chk("clr_s1", s1, 4'd0);
    chk("clr_ack", ack, 2'b00);
    req = 2'b00;
    clr = 1'b0;
    step(17);
    wait_an(4'b1011, "clr_wait_p1o");
    chk("clr_p1_ones", digit, 4'd0);
    step(4);
`ifdef SCORE_LZB_EN
    chk("clr_an_p1t", an, 4'b1111);
`else
    chk("clr_an_p1t", an, 4'b0111);
`endif
    chk("clr_p1_tens", digit, 4'd0);

    // score 7: tens slot lit or blanked
    do_reset();
    req = 2'b01;
    step(14);
    chk("lzb_s0", s0, 4'd7);
    req = 2'b00;
    step(17);
    wait_an(4'b1110, "lzb_wait_p0o");
    chk("lzb_p0_ones", digit, 4'd7);
    step(4);
`ifdef SCORE_LZB_EN
    chk("lzb_an_p0t", an, 4'b1111);
`else
    chk("lzb_an_p0t", an, 4'b1101);
`endif
    chk("lzb_dig_p0t", digit, 4'd0);

    // reset on the load edge right after a grant
    do_reset();
    step(3);
    req = 2'b01;
    step(1);
    req = 2'b00;
    chk("mid_ack", ack, 2'b01);
    chk("mid_s0", s0, 4'd1);
    chk("mid_bin", bin, 4'd1);
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_ack", ack, 2'b00);
    chk("mid_rst_s0", s0, 4'd0);
    chk("mid_rst_an", an, 4'b1111);
    chk("mid_rst_bin", bin, 4'd0);
    rst_n = 1'b1;
    step(4);
    chk("restart_an4", an, 4'b1111);
    step(1);
    chk("restart_an5", an, 4'b1110);
    chk("restart_dig", digit, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/score_scan_ctrl.md
# score_scan_ctrl

Sequencing controller for the shared 4-bit binary-to-BCD converter in the scoreboard path. It keeps two player scores and arbitrates increment requests between the two players round-robin. It time-multiplexes the single converter across the four display digits (P0 ones, P0 tens, P1 ones, P1 tens), latching each converted digit into the active-low anode/digit scan outputs that feed the seven-segment decoder.

## Interface
- `SCAN_DIV`, 100000: clock cycles per digit slot; legal range 2 to 2^20.
- `MAX_SCORE`, 15: saturation value per player; legal range 1 to 15.
- `clk`  in  1: sole clock; all state updates on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_inc`  in  2: per-player increment request, level; bit i = player i.
- `clr`  in  1: synchronous clear of both scores.
- `ack`  out  2: one-cycle grant pulse per player.
- `bin_out`  out  4: registered score presented to shared converter input.
- `bcd0_in`  in  4: converter ones digit (combinational from `bin_out`).
- `bcd1_in`  in  4: converter tens digit (combinational from `bin_out`).
- `an`  out  4: digit enables, active-low, one-hot-low or all-high.
- `digit`  out  4: BCD value for the currently enabled digit.
- `score0`, `score1`  out  4 each: current scores, for status/debug.

## Operation
- **Reset** (rst_n=0 at edge):
  - scores=0, `ack`=0, `bin_out`=0, `an`=4'b1111, `digit`=0.
  - divider cnt=0, idx=3, load flag=0, rr pointer=1, so player 0 wins the first tie.
  - Reset mid-scan or mid-grant aborts everything; no partial ack.
- **Arbiter**, evaluated every cycle:
  - Player i is eligible iff `req_inc[i]`=1 and `ack[i]`=0, so a held request cannot double-count on the ack cycle.
  - One eligible player: that player is granted.
  - Both eligible: the player other than the rr pointer is granted; the pointer updates to the granted player.
  - On grant at edge: `ack[i]`<=1 for exactly one cycle, and score i <= min(score i + 1, `MAX_SCORE`).
  - At saturation the ack is still issued and the score holds.
  - A continuously held request yields one increment every 2 cycles.
- **Clear**: `clr`=1 at an edge sets both scores to 0, issues no ack that cycle and leaves the rr pointer unchanged. Clear beats simultaneous requests.
- **Scan state machine**:
  - idx cycles through four states: 0=P0_ONES, 1=P0_TENS, 2=P1_ONES, 3=P1_TENS, wrapping 3->0.
  - TICK phase (cnt==`SCAN_DIV`-1): cnt<=0, idx<=idx+1, `bin_out`<=score of player (idx+1)>>1 using post-update values from that edge's arbiter, load<=1.
  - LOAD phase (load=1), next cycle:
    - `digit`<= (idx odd ? `bcd1_in` : `bcd0_in`);
    - `an`<= all ones with bit idx cleared;
    - load<=0.
  - Otherwise cnt increments.
- **Latency and update rules**:
  - A score change appears on the display at the next LOAD of that digit, i.e. within 4·`SCAN_DIV`+1 cycles.
  - `bin_out` does not follow score changes between ticks.
- **Widths**: scores are 4-bit unsigned; the converter splits them into tens 0..1 and ones 0..9.

## Timing
- TICK to new `an`/`digit`: 1 cycle.
- Digit period: `SCAN_DIV` cycles.
- Full frame: 4·`SCAN_DIV` cycles.
- Request sampled at edge E produces `ack` high from E to E+1 and the new score visible at E.
- `bcd*_in` are sampled only in the LOAD cycle. The converter's combinational path must settle within one cycle of `bin_out`.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SCORE_LZB_EN` defined (leading-zero blanking):
  - In the LOAD of a tens slot (idx 1 or 3) with `bcd1_in`==0, `an`<=4'b1111 and `digit`<=0.
- `SCORE_LZB_EN` undefined:
  - Tens digits always light and show 0 when the score is below 10.

## Test plan
- Reset held 3 cycles, then released with no requests, `SCAN_DIV`=4:
  - `an` sequence 1110, 1101, 1011, 0111 repeating every 16 cycles.
  - `digit` is always 0.
  - Each new `an` value appears 1 cycle after cnt==3.
- `req_inc`=2'b11 held 8 cycles from reset:
  - `ack` alternates 01, 10, 01, 10 with idle cycles between each player's own grants.
  - score0=score1=2 after cycle 4 and both reach 4 by cycle 8; no cycle has both ack bits high.
- score0 preset to 15 by 15 pulses, then one more request:
  - `ack[0]` pulses and score0 stays 15.
  - The display shows P0_ONES=5 and P0_TENS=1.
- score1=12, then `clr` and `req_inc[1]` asserted in the same cycle:
  - score1=0 and `ack`=0 that cycle.
  - The next P1 LOADs show 0 and 0.
- score0=7 with `SCORE_LZB_EN` defined:
  - The P0_TENS slot gives `an`=1111.
  - Without the macro, the slot gives `an`=1101 with `digit`=0.
- `rst_n` pulled low in the cycle after a grant and during a LOAD:
  - Next cycle: `ack`=0, scores 0, `an`=1111.
  - Scan restarts with P0_ONES first.
